wired_lsu_sb_ctrl: RTL and testbench
====================================

// Module: wired_lsu_sb_ctrl
// PURPOSE
// - Store-buffer (SB) controller for the LSU: circular FIFO over SB_DEPTH wired_lsu_sb_entry slots, oldest-first.
// - Three pointers: tail (allocate), cmt (next to commit), head (next to drain).
// - Drives per-entry create/invalidate strobes; drains committed entries to the dcache SRAM write port.
// - A drain that finds no writable hit requests a refill from the miss handler, then retries.
// PARAMETERS
// - SB_DEPTH  4  entry count; power of two, >=2. PTR_W = $clog2(SB_DEPTH)+1 (MSB = wrap bit).
// PORTS
// - clk            in   1                          clock
// - rst_n          in   1                          async active-low reset
// - alloc_valid_i  in   1                          new store requests an entry
// - alloc_ready_o  out  1                          entry available (not full, no flush this cycle)
// - alloc_idx_o    out  $clog2(SB_DEPTH)           slot index given to the accepted store
// - commit_i       in   1                          ROB retires the oldest uncommitted store
// - flush_i        in   1                          discard all uncommitted entries
// - ent_alloc_o    out  SB_DEPTH                   one-hot create strobe (entry valid_i)
// - ent_free_o     out  SB_DEPTH                   invalidate strobes (entry invalid_i)
// - ent_meta_i     in   SB_DEPTH x sb_meta_t       live, snooped entry metadata
// - dwr_valid_o    out  1                          SRAM store write request for the head entry
// - dwr_ready_i    in   1                          SRAM write accepted
// - dwr_idx_o      out  $clog2(SB_DEPTH)           head slot index
// - dwr_way_o      out  4                          one-hot way: lowest set bit of head meta.hit
// - refill_valid_o out  1                          refill request for the head paddr
// - refill_ready_i in   1                          miss handler accepted the request
// - refill_paddr_o out  32                         head meta.paddr
// - refill_done_i  in   1                          refill complete (snoop has already updated hit)
// - empty_o        out  1                          no valid entries (fence / uncached ordering)
// BEHAVIOUR
// - Reset: tail=cmt=head=0, FSM=D_IDLE, all strobes/valids 0, empty_o=1, alloc_ready_o=1.
// - Occupancy: cnt = tail-head; committed count ccnt = cmt-head (PTR_W modular).
//   - full: cnt==SB_DEPTH. empty_o: cnt==0. Wrap-bit compare; indices wrap SB_DEPTH-1 -> 0.
// - Alloc: fire = alloc_valid_i & alloc_ready_o.
//   - On fire: ent_alloc_o[tail] pulses the same cycle; alloc_idx_o = tail[PTR_W-2:0]; tail++ at the edge.
//   - alloc_ready_o = !full & !flush_i. A drain completing in the same cycle does NOT free space for that alloc.
// - Commit: commit_i with cmt!=tail -> cmt++.
//   - commit_i with cmt==tail is ignored (assertion error).
// - Flush: tail <= cmt at the edge.
//   - ent_free_o pulses for every slot in [cmt, tail).
//   - Same-cycle commit_i is applied first: cmt+1 survives, tail <= cmt+1.
//   - Committed entries and the drain FSM are unaffected.
// - Drain FSM (registered):
//   - D_IDLE: if ccnt!=0 -> (|meta[head].hit ? D_WRITE : D_REFILL).
//   - D_WRITE: dwr_valid_o=1.
//     - On dwr_ready_i: ent_free_o[head] pulse, head++, -> D_IDLE.
//     - If hit drops to 0 by snoop before acceptance: dwr_valid_o deasserts that cycle, -> D_REFILL.
//   - D_REFILL: refill_valid_o=1; on refill_ready_i -> D_WAIT.
//   - D_WAIT: on refill_done_i -> D_IDLE (re-evaluates hit).
// - Latency:
//   - Commit at edge t, hit set -> dwr_valid_o high in cycle t+2 (t+1 = IDLE decision).
//   - Sustained throughput: one entry per 2 cycles.
// - Flush and drain-free strobes never target the same slot: drain touches only committed slots.
// - Async reset mid-drain: FSM -> D_IDLE; entry contents are don't-care, since pointers reset.
// CONFIGURATION
// - WIRED_SB_CTRL_STAT_EN defined:
//   - Adds outputs stat_drain_o[31:0] and stat_refill_o[31:0].
//   - Counters wrap, reset 0; ++ on each accepted dwr / refill request.
// - Not defined: those ports and counters are absent; all other behaviour is identical.
// TESTING
// - Fill 4 allocs back-to-back -> alloc_idx 0,1,2,3; alloc_ready_o=0 on the 5th cycle; empty_o=0.
// - 2 allocs, commit both, hit=4'b0100, dwr_ready_i=1 -> dwr_way_o=4'b0100; frees idx0 then idx1, 2 cycles apart.
// - 3 allocs, commit 1, flush_i -> ent_free_o=4'b0110; tail=1; the committed entry still drains.
// - Head hit=0 -> refill_valid_o with head paddr; refill_done_i + hit=4'b0001 -> dwr_valid_o 2 cycles later.
// - Wrap: 6 alloc/commit/drain rounds -> indices 0..3,0,1; no false full/empty at wrap.
// - Hold dwr_ready_i=0, snoop clears hit -> dwr_valid_o drops, FSM issues refill; rst_n low mid-WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/wired_lsu_sb_ctrl.sv
// Store-buffer controller: circular FIFO of entries with allocate/commit/drain pointers and a refill-retry drain FSM.
// Optional drain/refill statistics counters are built when WIRED_SB_CTRL_STAT_EN is defined.
package wired_lsu_sb_pkg;
  typedef struct packed {
    logic [31:0] paddr;
    logic [3:0]  hit;
  } sb_meta_t;
endpackage

module wired_lsu_sb_ctrl
  import wired_lsu_sb_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  localparam int IDX_W = $clog2(SB_DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid_i,
  output logic                      alloc_ready_o,
  output logic [IDX_W-1:0]          alloc_idx_o,
  input  logic                      commit_i,
  input  logic                      flush_i,
  output logic [SB_DEPTH-1:0]       ent_alloc_o,
  output logic [SB_DEPTH-1:0]       ent_free_o,
  input  sb_meta_t [SB_DEPTH-1:0]   ent_meta_i,
  output logic                      dwr_valid_o,
  input  logic                      dwr_ready_i,
  output logic [IDX_W-1:0]          dwr_idx_o,
  output logic [3:0]                dwr_way_o,
  output logic                      refill_valid_o,
  input  logic                      refill_ready_i,
  output logic [31:0]               refill_paddr_o,
  input  logic                      refill_done_i,
  output logic                      empty_o
`ifdef WIRED_SB_CTRL_STAT_EN
  ,
  output logic [31:0]               stat_drain_o,
  output logic [31:0]               stat_refill_o
`endif
);

  typedef enum logic [1:0] {D_IDLE, D_WRITE, D_REFILL, D_WAIT} d_state_t;

  d_state_t         state;
  logic [PTR_W-1:0] tail, cmt, head;
  logic [PTR_W-1:0] cnt, ccnt, cmt_nxt, pend;
  logic [IDX_W-1:0] head_idx, off;
  sb_meta_t         head_meta;
  logic             head_hit, full, alloc_fire, commit_ok, dwr_fire, refill_fire;

  assign cnt        = tail - head;
  assign ccnt       = cmt - head;
  assign full       = (cnt == PTR_W'(SB_DEPTH));
  assign empty_o    = (cnt == '0);
  assign head_idx   = head[IDX_W-1:0];
  assign head_meta  = ent_meta_i[head_idx];
  assign head_hit   = |head_meta.hit;

  assign alloc_ready_o = !full && !flush_i;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign alloc_idx_o   = tail[IDX_W-1:0];
  assign commit_ok     = commit_i && (cmt != tail);
  // A same-cycle commit is applied before the flush rewinds tail.
  assign cmt_nxt       = cmt + PTR_W'(commit_ok);

  // Hit is snooped live, so a write request withdraws as soon as the hit is lost.
  assign dwr_valid_o    = (state == D_WRITE) && head_hit;
  assign dwr_fire       = dwr_valid_o && dwr_ready_i;
  assign dwr_idx_o      = head_idx;
  assign dwr_way_o      = head_meta.hit & (~head_meta.hit + 4'd1);
  assign refill_valid_o = (state == D_REFILL);
  assign refill_fire    = refill_valid_o && refill_ready_i;
  assign refill_paddr_o = head_meta.paddr;

  always_comb begin
    ent_alloc_o = '0;
    ent_free_o  = '0;
    off         = '0;
    pend        = tail - cmt_nxt;
    if (alloc_fire) ent_alloc_o[alloc_idx_o] = 1'b1;
    if (flush_i) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        off = IDX_W'(i) - cmt_nxt[IDX_W-1:0];
        if ({1'b0, off} < pend) ent_free_o[i] = 1'b1;
      end
    end
    if (dwr_fire) ent_free_o[head_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail  <= '0;
      cmt   <= '0;
      head  <= '0;
      state <= D_IDLE;
    end else begin
      cmt <= cmt_nxt;
      if (flush_i)         tail <= cmt_nxt;
      else if (alloc_fire) tail <= tail + PTR_W'(1);
      if (dwr_fire)        head <= head + PTR_W'(1);
      case (state)
        D_IDLE:   if (ccnt != '0) state <= head_hit ? D_WRITE : D_REFILL;
        D_WRITE: begin
          if (!head_hit)        state <= D_REFILL;
          else if (dwr_ready_i) state <= D_IDLE;
        end
        D_REFILL: if (refill_ready_i) state <= D_WAIT;
        D_WAIT:   if (refill_done_i)  state <= D_IDLE;
        default:  state <= D_IDLE;
      endcase
    end
  end

`ifdef WIRED_SB_CTRL_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_drain_o  <= '0;
      stat_refill_o <= '0;
    end else begin
      if (dwr_fire)    stat_drain_o  <= stat_drain_o + 32'd1;
      if (refill_fire) stat_refill_o <= stat_refill_o + 32'd1;
    end
  end
`endif

  commit_on_empty_a: assert property (@(posedge clk) disable iff (!rst_n) !(commit_i && (cmt == tail)))
    else $error("commit_i with no uncommitted store");

endmodule

// File: tb/tb_wired_lsu_sb_ctrl.sv
// Self-checking bench for wired_lsu_sb_ctrl: directed scenarios plus a randomized run against a queue model.
module tb_wired_lsu_sb_ctrl;
  import wired_lsu_sb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic alloc_valid, alloc_ready, commit, flush;
  logic [1:0] alloc_idx, dwr_idx;
  logic [3:0] ent_alloc, ent_free, dwr_way;
  logic dwr_valid, dwr_ready, refill_valid, refill_ready, refill_done, empty;
  logic [31:0] refill_paddr;
  sb_meta_t [3:0] ent_meta;
  logic [3:0]  m_hit [4];
  logic [31:0] m_paddr [4];
`ifdef WIRED_SB_CTRL_STAT_EN
  logic [31:0] stat_drain, stat_refill;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ent_meta[i].paddr = m_paddr[i];
      ent_meta[i].hit   = m_hit[i];
    end
  end

  wired_lsu_sb_ctrl #(.SB_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
    .commit_i(commit), .flush_i(flush),
    .ent_alloc_o(ent_alloc), .ent_free_o(ent_free), .ent_meta_i(ent_meta),
    .dwr_valid_o(dwr_valid), .dwr_ready_i(dwr_ready), .dwr_idx_o(dwr_idx), .dwr_way_o(dwr_way),
    .refill_valid_o(refill_valid), .refill_ready_i(refill_ready), .refill_paddr_o(refill_paddr),
    .refill_done_i(refill_done), .empty_o(empty)
`ifdef WIRED_SB_CTRL_STAT_EN
    , .stat_drain_o(stat_drain), .stat_refill_o(stat_refill)
`endif
  );

  task next_cycle();
    @(posedge clk);
    #1;
  endtask

  task idle_inputs();
    alloc_valid = 0; commit = 0; flush = 0;
    dwr_ready = 0; refill_ready = 0; refill_done = 0;
  endtask

  task set_all_hit(input logic [3:0] h);
    for (int i = 0; i < 4; i++) begin
      m_hit[i] = h;
      m_paddr[i] = $urandom;
    end
  endtask

  task do_reset();
    idle_inputs();
    rst_n = 0;
    next_cycle();
    next_cycle();
    rst_n = 1;
  endtask

  task test_reset();
    idle_inputs();
    set_all_hit(4'b0000);
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({empty, alloc_ready, dwr_valid, refill_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_ctrl got empty/ready/dwr/refill=%b exp 1100",
               {empty, alloc_ready, dwr_valid, refill_valid});
    end
    checks++;
    if ({ent_alloc, ent_free} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes got alloc=%b free=%b exp 0", ent_alloc, ent_free);
    end
    next_cycle();
    rst_n = 1;
  endtask

  task test_fill();
    logic [3:0] exp;
    do_reset();
    set_all_hit(4'b0001);
    for (int k = 0; k < 4; k++) begin
      alloc_valid = 1;
      exp = 4'b0001 << k;
      @(negedge clk);
      checks++;
      if (alloc_ready !== 1'b1 || alloc_idx !== 2'(k) || ent_alloc !== exp) begin
        errors++;
        $display("FAIL fill_alloc%0d got ready=%b idx=%0d strobe=%b exp 1 %0d %b",
                 k, alloc_ready, alloc_idx, ent_alloc, k, exp);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (alloc_ready !== 1'b0 || empty !== 1'b0 || ent_alloc !== 4'b0000) begin
      errors++;
      $display("FAIL fill_full got ready=%b empty=%b strobe=%b exp 0 0 0000",
               alloc_ready, empty, ent_alloc);
    end
    alloc_valid = 0;
  endtask

  task test_drain();
    do_reset();
    set_all_hit(4'b0100);
    dwr_ready = 1;
    alloc_valid = 1; next_cycle();
    next_cycle();
    alloc_valid = 0; commit = 1; next_cycle();
    @(negedge clk);
    checks++;
    if (dwr_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle_cycle got dwr_valid=%b exp 0", dwr_valid);
    end
    next_cycle();
    commit = 0;
    @(negedge clk);
    checks++;
    if (dwr_valid !== 1'b1 || dwr_way !== 4'b0100 || dwr_idx !== 2'd0 || ent_free !== 4'b0001) begin
      errors++;
      $display("FAIL drain_first got valid=%b way=%b idx=%0d free=%b exp 1 0100 0 0001",
               dwr_valid, dwr_way, dwr_idx, ent_free);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (dwr_valid !== 1'b0 || ent_free !== 4'b0000) begin
      errors++;
      $display("FAIL drain_gap got valid=%b free=%b exp 0 0000", dwr_valid, ent_free);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (dwr_idx !== 2'd1 || ent_free !== 4'b0010) begin
      errors++;
      $display("FAIL drain_second got idx=%0d free=%b exp 1 0010", dwr_idx, ent_free);
    end
    next_cycle();
    dwr_ready = 0;
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty got empty=%b exp 1", empty);
    end
  endtask

  task test_flush();
    do_reset();
    set_all_hit(4'b0001);
    alloc_valid = 1;
    repeat (3) next_cycle();
    alloc_valid = 0; commit = 1; next_cycle();
    commit = 0; flush = 1;
    @(negedge clk);
    checks++;
    if (ent_free !== 4'b0110 || alloc_ready !== 1'b0 || dwr_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_free got free=%b ready=%b dwr=%b exp 0110 0 0", ent_free, alloc_ready, dwr_valid);
    end
    next_cycle();
    flush = 0; alloc_valid = 1;
    @(negedge clk);
    checks++;
    if (alloc_idx !== 2'd1 || ent_alloc !== 4'b0010 || dwr_valid !== 1'b1 || dwr_idx !== 2'd0) begin
      errors++;
      $display("FAIL flush_tail got idx=%0d strobe=%b dwr=%b didx=%0d exp 1 0010 1 0",
               alloc_idx, ent_alloc, dwr_valid, dwr_idx);
    end
    next_cycle();
    alloc_valid = 0; dwr_ready = 1;
    @(negedge clk);
    checks++;
    if (ent_free !== 4'b0001) begin
      errors++;
      $display("FAIL flush_committed_drain got free=%b exp 0001", ent_free);
    end
    next_cycle();
    dwr_ready = 0;
    @(negedge clk);
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("FAIL flush_remaining got empty=%b exp 0", empty);
    end
  endtask

  task test_refill();
    do_reset();
    set_all_hit(4'b0000);
    alloc_valid = 1; next_cycle();
    alloc_valid = 0; commit = 1; next_cycle();
    commit = 0;
    @(negedge clk);
    checks++;
    if (refill_valid !== 1'b0) begin
      errors++;
      $display("FAIL refill_idle got refill_valid=%b exp 0", refill_valid);
    end
    next_cycle();
    refill_ready = 1;
    @(negedge clk);
    checks++;
    if (refill_valid !== 1'b1 || refill_paddr !== m_paddr[0] || dwr_valid !== 1'b0) begin
      errors++;
      $display("FAIL refill_req got valid=%b paddr=%h dwr=%b exp 1 %h 0",
               refill_valid, refill_paddr, dwr_valid, m_paddr[0]);
    end
    next_cycle();
    refill_ready = 0;
    @(negedge clk);
    checks++;
    if (refill_valid !== 1'b0) begin
      errors++;
      $display("FAIL refill_wait got refill_valid=%b exp 0", refill_valid);
    end
    next_cycle();
    m_hit[0] = 4'b0001; refill_done = 1;
    next_cycle();
    refill_done = 0;
    @(negedge clk);
    checks++;
    if (dwr_valid !== 1'b0) begin
      errors++;
      $display("FAIL refill_reeval got dwr_valid=%b exp 0", dwr_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (dwr_valid !== 1'b1 || dwr_way !== 4'b0001) begin
      errors++;
      $display("FAIL refill_write got valid=%b way=%b exp 1 0001", dwr_valid, dwr_way);
    end
  endtask

  task test_wrap();
    logic got;
    logic [3:0] exp;
    do_reset();
    set_all_hit(4'b0011);
    dwr_ready = 1;
    for (int r = 0; r < 6; r++) begin
      alloc_valid = 1;
      @(negedge clk);
      checks++;
      if (alloc_idx !== 2'(r % 4) || alloc_ready !== 1'b1 || empty !== 1'b1) begin
        errors++;
        $display("FAIL wrap_alloc%0d got idx=%0d ready=%b empty=%b exp %0d 1 1",
                 r, alloc_idx, alloc_ready, empty, r % 4);
      end
      next_cycle();
      alloc_valid = 0; commit = 1; next_cycle();
      commit = 0;
      got = 0;
      exp = 4'b0001 << (r % 4);
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        if (ent_free !== 4'b0000) begin
          got = 1;
          checks++;
          if (ent_free !== exp || dwr_way !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_free%0d got free=%b way=%b exp %b 0001", r, ent_free, dwr_way, exp);
          end
        end
        next_cycle();
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL wrap_timeout%0d got no free strobe exp %b", r, exp);
      end
    end
    dwr_ready = 0;
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_final got empty=%b ready=%b exp 1 1", empty, alloc_ready);
    end
  endtask

  task test_snoop_reset();
    do_reset();
    set_all_hit(4'b0010);
    alloc_valid = 1; next_cycle();
    alloc_valid = 0; commit = 1; next_cycle();
    commit = 0; next_cycle();
    @(negedge clk);
    checks++;
    if (dwr_valid !== 1'b1 || dwr_way !== 4'b0010) begin
      errors++;
      $display("FAIL snoop_write got valid=%b way=%b exp 1 0010", dwr_valid, dwr_way);
    end
    next_cycle();
    m_hit[0] = 4'b0000;
    @(negedge clk);
    checks++;
    if (dwr_valid !== 1'b0) begin
      errors++;
      $display("FAIL snoop_drop got dwr_valid=%b exp 0", dwr_valid);
    end
    next_cycle();
    refill_ready = 1;
    @(negedge clk);
    checks++;
    if (refill_valid !== 1'b1) begin
      errors++;
      $display("FAIL snoop_refill got refill_valid=%b exp 1", refill_valid);
    end
    next_cycle();
    refill_ready = 0;
    @(negedge clk);
    checks++;
    if (refill_valid !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL snoop_wait got refill_valid=%b empty=%b exp 0 0", refill_valid, empty);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({empty, alloc_ready, dwr_valid, refill_valid} !== 4'b1100 || {ent_alloc, ent_free} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got empty/ready/dwr/refill=%b alloc=%b free=%b exp 1100 0 0",
               {empty, alloc_ready, dwr_valid, refill_valid}, ent_alloc, ent_free);
    end
    next_cycle();
    rst_n = 1;
  endtask

  task test_random();
    int unc[$];
    int com[$];
    int nslot, total, lb;
    logic fire, drain, exp_ready;
    logic [3:0] exp_alloc, exp_free;
    do_reset();
    for (int i = 0; i < 4; i++) m_hit[i] = 4'($urandom_range(1, 15));
    nslot = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      alloc_valid = 1'($urandom_range(0, 1));
      commit      = (unc.size() > 0) && ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      dwr_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
      total     = unc.size() + com.size();
      exp_ready = (total != 4) && !flush;
      fire      = alloc_valid && exp_ready;
      checks++;
      if (alloc_ready !== exp_ready || empty !== (total == 0)) begin
        errors++;
        $display("FAIL rnd_status cyc%0d got ready=%b empty=%b exp %b %b",
                 cyc, alloc_ready, empty, exp_ready, total == 0);
      end
      exp_alloc = fire ? (4'b0001 << nslot) : 4'b0000;
      checks++;
      if (ent_alloc !== exp_alloc || (fire && alloc_idx !== 2'(nslot))) begin
        errors++;
        $display("FAIL rnd_alloc cyc%0d got strobe=%b idx=%0d exp %b %0d", cyc, ent_alloc, alloc_idx, exp_alloc, nslot);
      end
      drain = dwr_valid && dwr_ready;
      exp_free = 4'b0000;
      if (dwr_valid) begin
        checks++;
        if (com.size() == 0) begin
          errors++;
          $display("FAIL rnd_dwr_nocommit cyc%0d got dwr_valid=1 exp 0", cyc);
        end else begin
          lb = 0;
          for (int k = 3; k >= 0; k--) if (m_hit[com[0]][k]) lb = k;
          if (dwr_idx !== 2'(com[0]) || dwr_way !== (4'b0001 << lb)) begin
            errors++;
            $display("FAIL rnd_dwr cyc%0d got idx=%0d way=%b exp %0d %b", cyc, dwr_idx, dwr_way, com[0], 4'b0001 << lb);
          end
          if (drain) exp_free[com[0]] = 1'b1;
        end
      end
      if (flush) for (int j = (commit ? 1 : 0); j < unc.size(); j++) exp_free[unc[j]] = 1'b1;
      checks++;
      if (ent_free !== exp_free) begin
        errors++;
        $display("FAIL rnd_free cyc%0d got %b exp %b", cyc, ent_free, exp_free);
      end
      next_cycle();
      if (drain && com.size() > 0) void'(com.pop_front());
      if (commit) com.push_back(unc.pop_front());
      if (flush) begin
        if (unc.size() > 0) nslot = unc[0];
        unc.delete();
      end else if (fire) begin
        unc.push_back(nslot);
        nslot = (nslot + 1) % 4;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_flush();
    test_refill();
    test_wrap();
    test_snoop_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
